// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one RAMB36E1 port between two requesters, with a tag pipe returning read data.
// Define BRAM_ARB_DOREG_EN when the attached BRAM uses DO_REG=1 (read latency grows from 3 to 4).
module bram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [DATA_W-1:0]     bram_wdata,
    input  logic [DATA_W-1:0]     bram_rdata
);

`ifdef BRAM_ARB_DOREG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int TAG_DEPTH = LAT - 1;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    logic                      r_prio;
    logic                      r_bram_en;
    logic                      r_bram_we;
    logic [ADDR_W-1:0]         r_bram_addr;
    logic [DATA_W-1:0]         r_bram_wdata;
    logic [1:0]                r_rsp_valid;
    logic [DATA_W-1:0]         r_rsp_rdata;
    tag_t [TAG_DEPTH-1:0]      r_tag;

    logic [1:0]                w_ready;
    logic [1:0]                w_fire;
    logic                      w_fire_any;
    logic                      w_fire_id;
    logic [ADDR_W-1:0]         w_sel_addr;
    logic [DATA_W-1:0]         w_sel_wdata;
    tag_t                      w_new_tag;
    tag_t                      w_last_tag;

    // NOTE: w_ready gets a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_ready = 2'b00;
        if (!rst) begin
            case (req_valid)
                2'b01:   w_ready = 2'b01;
                2'b10:   w_ready = 2'b10;
                2'b11:   w_ready = r_prio ? 2'b10 : 2'b01;
                default: w_ready = 2'b00;
            endcase
        end
    end

    assign req_ready   = w_ready;
    assign w_fire      = req_valid & w_ready;
    assign w_fire_any  = |w_fire;
    assign w_fire_id   = w_fire[1];
    assign w_sel_addr  = w_fire_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign w_sel_wdata = w_fire_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    assign w_new_tag   = '{valid: w_fire_any && !req_we[w_fire_id], id: w_fire_id};
    assign w_last_tag  = r_tag[TAG_DEPTH-1];

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio       <= 1'b0;
            r_bram_en    <= 1'b0;
            r_bram_we    <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_wdata <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_rdata  <= '0;
            // NOTE: the tag pipe is control state and is cleared so in-flight reads are dropped; bulk data storage would not be reset.
            r_tag        <= '0;
        end else begin
            r_bram_en <= w_fire_any;
            r_bram_we <= w_fire_any && req_we[w_fire_id];
            if (w_fire_any) begin
                r_prio       <= ~w_fire_id;
                r_bram_addr  <= w_sel_addr;
                r_bram_wdata <= w_sel_wdata;
            end
            if (TAG_DEPTH > 1) begin
                r_tag <= {r_tag[TAG_DEPTH-2:0], w_new_tag};
            end else begin
                r_tag[0] <= w_new_tag;
            end
            r_rsp_valid <= {w_last_tag.valid & w_last_tag.id, w_last_tag.valid & ~w_last_tag.id};
            if (w_last_tag.valid) begin
                r_rsp_rdata <= bram_rdata;
            end
        end
    end

    assign bram_en    = r_bram_en;
    assign bram_we    = r_bram_we;
    assign bram_addr  = r_bram_addr;
    assign bram_wdata = r_bram_wdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;

endmodule
